pkt_arbiter: RTL and testbench

PKT_ARBITER -- requirements
Module: pkt_arbiter

---
 rtl/pkt_arbiter.sv | 133 +++++++++++++
 tb/tb_pkt_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arbiter.sv
// Two-source packet arbiter: picks a source while idle, then forwards its
// whole packet word by word to a single downstream port. Ties between the
// sources are broken round robin. Completed packets are counted per source,
// and a sticky flag records any packet longer than MAX_PKT_WORDS.
module pkt_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int MAX_PKT_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [CTRL_WIDTH-1:0] in0_ctrl,
  input  logic                  in0_empty,
  output logic                  in0_rd_en,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [CTRL_WIDTH-1:0] in1_ctrl,
  input  logic                  in1_empty,
  output logic                  in1_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic                  err_long
);

  // The word counter must be able to represent MAX_PKT_WORDS + 1 so that the
  // overflow transfer is still distinguishable after it saturates.
  localparam int WC_WIDTH = $clog2(MAX_PKT_WORDS + 2);
  localparam logic [WC_WIDTH-1:0] MAX_WC = WC_WIDTH'(MAX_PKT_WORDS);

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic [WC_WIDTH-1:0]   word_cnt_reg, word_cnt_next;
  logic [CNT_WIDTH-1:0]  pkt_cnt0_reg, pkt_cnt0_next;
  logic [CNT_WIDTH-1:0]  pkt_cnt1_reg, pkt_cnt1_next;
  logic                  err_long_reg, err_long_next;
  logic                  grant_empty;
  logic [CTRL_WIDTH-1:0] head_ctrl;

  assign pkt_cnt0 = pkt_cnt0_reg;
  assign pkt_cnt1 = pkt_cnt1_reg;
  assign err_long = err_long_reg;

  // State register: all control and statistics state, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      word_cnt_reg   <= '0;
      pkt_cnt0_reg   <= '0;
      pkt_cnt1_reg   <= '0;
      err_long_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      word_cnt_reg   <= word_cnt_next;
      pkt_cnt0_reg   <= pkt_cnt0_next;
      pkt_cnt1_reg   <= pkt_cnt1_next;
      err_long_reg   <= err_long_next;
    end
  end

  // Next-state and output logic: arbitration in IDLE, transfers in HDR/BODY.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    word_cnt_next   = word_cnt_reg;
    pkt_cnt0_next   = pkt_cnt0_reg;
    pkt_cnt1_next   = pkt_cnt1_reg;
    err_long_next   = err_long_reg;
    out_wr          = 1'b0;
    in0_rd_en       = 1'b0;
    in1_rd_en       = 1'b0;
    grant_empty     = grant_reg ? in1_empty : in0_empty;
    head_ctrl       = grant_reg ? in1_ctrl  : in0_ctrl;
    out_data        = grant_reg ? in1_data  : in0_data;
    out_ctrl        = head_ctrl;

    case (state_reg)
      IDLE: begin
        word_cnt_next = '0;
        if (!in0_empty && !in1_empty) begin
          grant_next = ~last_grant_reg;
          state_next = HDR;
        end else if (!in0_empty) begin
          grant_next = 1'b0;
          state_next = HDR;
        end else if (!in1_empty) begin
          grant_next = 1'b1;
          state_next = HDR;
        end
      end
      HDR, BODY: begin
        if (!grant_empty && out_rdy) begin
          out_wr    = 1'b1;
          in0_rd_en = ~grant_reg;
          in1_rd_en = grant_reg;
          if (word_cnt_reg >= MAX_WC) err_long_next = 1'b1;
          if (word_cnt_reg != '1) word_cnt_next = word_cnt_reg + WC_WIDTH'(1);
          if (state_reg == HDR) begin
            if (head_ctrl == '0) state_next = BODY;
          end else if (head_ctrl != '0) begin
            // First control word after the body closes the packet.
            state_next      = IDLE;
            last_grant_next = grant_reg;
            word_cnt_next   = '0;
            if (grant_reg) pkt_cnt1_next = pkt_cnt1_reg + CNT_WIDTH'(1);
            else           pkt_cnt0_next = pkt_cnt0_reg + CNT_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // No strobes may leave the block while reset is held.
    if (reset) begin
      out_wr    = 1'b0;
      in0_rd_en = 1'b0;
      in1_rd_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_arbiter.sv
// Self-checking bench for pkt_arbiter: fall-through FIFOs modelled as queues,
// a packet-level reference model checked every cycle, directed scenarios and
// a randomized phase.
module tb_pkt_arbiter;
  localparam int DW   = 16;
  localparam int CW   = 8;
  localparam int NW   = 2;
  localparam int MAXW = 8;

  typedef logic [CW+DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic [CW-1:0] in0_ctrl, in1_ctrl, out_ctrl;
  logic          in0_empty, in1_empty, in0_rd_en, in1_rd_en;
  logic          out_wr, out_rdy, err_long;
  logic [NW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  pkt_arbiter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW), .MAX_PKT_WORDS(MAXW)
  ) dut (
    .clk(clk), .reset(reset),
    .in0_data(in0_data), .in0_ctrl(in0_ctrl), .in0_empty(in0_empty), .in0_rd_en(in0_rd_en),
    .in1_data(in1_data), .in1_ctrl(in1_ctrl), .in1_empty(in1_empty), .in1_rd_en(in1_rd_en),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .err_long(err_long)
  );

  word_t fifo0[$], fifo1[$];   // words visible to the DUT
  word_t exp0[$], exp1[$];     // reference copies, consumed by the model
  bit    force_e0, force_e1;   // mask a source as empty (underrun)
  int    n_cmp = 0, n_mis = 0;
  int    wr_cycles = 0;

  // Reference model: which source owns the output, per-packet word count.
  int m_cur = -1, m_last = 1, m_wc = 0;
  int m_cnt[2];
  bit m_body, m_err;
  int m_order[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    in0_empty = (fifo0.size() == 0) || force_e0;
    in1_empty = (fifo1.size() == 0) || force_e1;
    {in0_ctrl, in0_data} = (fifo0.size() != 0) ? fifo0[0] : '0;
    {in1_ctrl, in1_data} = (fifo1.size() != 0) ? fifo1[0] : '0;
  endfunction

  function automatic void push_word(input int src, input logic [CW-1:0] c, input logic [DW-1:0] d);
    if (src == 0) begin fifo0.push_back({c, d}); exp0.push_back({c, d}); end
    else          begin fifo1.push_back({c, d}); exp1.push_back({c, d}); end
  endfunction

  function automatic void push_pkt(input int src, input int nh, input int nb);
    for (int i = 0; i < nh; i++) push_word(src, CW'($urandom_range(1, 255)), DW'($urandom));
    for (int i = 0; i < nb; i++) push_word(src, '0, DW'($urandom));
    push_word(src, CW'($urandom_range(1, 255)), DW'($urandom));
  endfunction

  function automatic void flush();
    fifo0.delete(); fifo1.delete(); exp0.delete(); exp1.delete();
  endfunction

  // One cycle of the reference model, evaluated with inputs stable.
  task automatic model_step();
    bit    x;
    word_t w;
    if (reset) begin
      check("rst_out_wr", out_wr, 0);
      check("rst_rd0", in0_rd_en, 0);
      check("rst_rd1", in1_rd_en, 0);
      m_cur = -1; m_last = 1; m_wc = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      m_body = 0; m_err = 0; m_order.delete();
      return;
    end
    check("pkt_cnt0", pkt_cnt0, m_cnt[0]);
    check("pkt_cnt1", pkt_cnt1, m_cnt[1]);
    check("err_long", err_long, m_err);
    if (m_cur < 0) begin
      check("idle_out_wr", out_wr, 0);
      check("idle_rd0", in0_rd_en, 0);
      check("idle_rd1", in1_rd_en, 0);
      if (!in0_empty && !in1_empty) m_cur = 1 - m_last;
      else if (!in0_empty)          m_cur = 0;
      else if (!in1_empty)          m_cur = 1;
      m_wc = 0; m_body = 0;
    end else begin
      x = ((m_cur == 0) ? !in0_empty : !in1_empty) && out_rdy;
      check("out_wr", out_wr, x);
      check("rd0", in0_rd_en, x && (m_cur == 0));
      check("rd1", in1_rd_en, x && (m_cur == 1));
      if (x) begin
        if ((m_cur == 0 ? exp0.size() : exp1.size()) == 0) begin
          check("exp_underflow", 1, 0);
          return;
        end
        w = (m_cur == 0) ? exp0.pop_front() : exp1.pop_front();
        check("out_data", out_data, w[DW-1:0]);
        check("out_ctrl", out_ctrl, w[CW+DW-1:DW]);
        wr_cycles++;
        m_wc++;
        if (m_wc > MAXW) m_err = 1;
        if (w[CW+DW-1:DW] != 0 && m_body) begin
          m_cnt[m_cur] = (m_cnt[m_cur] + 1) % (1 << NW);
          $display("pkt src%0d words=%0d cnt=%0d err=%0d", m_cur, m_wc, m_cnt[m_cur], m_err);
          m_last = m_cur;
          m_order.push_back(m_cur);
          m_cur = -1;
        end else if (w[CW+DW-1:DW] == 0) begin
          m_body = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    bit p0, p1;
    drive();
    @(negedge clk);
    p0 = in0_rd_en;
    p1 = in1_rd_en;
    model_step();
    @(posedge clk);
    #1;
    if (p0 && fifo0.size() != 0) void'(fifo0.pop_front());
    if (p1 && fifo1.size() != 0) void'(fifo1.pop_front());
  endtask

  // Reset for two cycles; the first one sees whatever the FIFOs still hold.
  task automatic do_reset(input bit flush_fifos);
    reset = 1'b1;
    cycle();
    if (flush_fifos) flush();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run_until_pkts(input int n, input int budget);
    int k = 0;
    while (m_order.size() < n && k < budget) begin cycle(); k++; end
    if (m_order.size() < n) check("timeout_pkts", m_order.size(), n);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    out_rdy = 1'b1; force_e0 = 0; force_e1 = 0;
    while (!(m_cur < 0 && fifo0.size() == 0 && fifo1.size() == 0) && k < budget) begin
      cycle(); k++;
    end
    if (k >= budget) check("timeout_drain", k, 0);
    cycle();
  endtask

  task automatic wait_body(input int src, input int budget);
    int k = 0;
    while (!(m_cur == src && m_body) && k < budget) begin cycle(); k++; end
    if (k >= budget) check("timeout_body", k, 0);
  endtask

  initial begin
    reset = 1'b1; out_rdy = 1'b1; force_e0 = 0; force_e1 = 0;

    // Tie after reset: both loaded with two 4-word packets each.
    push_pkt(0, 1, 2); push_pkt(0, 1, 2);
    push_pkt(1, 1, 2); push_pkt(1, 1, 2);
    do_reset(0);
    check("rst_cnt0", pkt_cnt0, 0);
    check("rst_cnt1", pkt_cnt1, 0);
    check("rst_err", err_long, 0);
    run_until_pkts(3, 100);
    check("tie_first", m_order[0], 0);
    check("tie_second", m_order[1], 1);
    check("tie_third", m_order[2], 0);
    drain(100);

    // Single source: hdr, 3 body, last -> 5 writes after one idle cycle.
    do_reset(1);
    push_word(0, 8'hFF, 16'h1000);
    for (int i = 1; i <= 3; i++) push_word(0, 8'h00, 16'(16'h1000 + i));
    push_word(0, 8'h01, 16'h1004);
    wr_cycles = 0;
    drain(50);
    check("single_wr_cycles", wr_cycles, 5);
    check("single_cnt0", pkt_cnt0, 1);
    check("single_cnt1", pkt_cnt1, 0);

    // Backpressure: out_rdy toggles every cycle once the body is reached.
    push_pkt(0, 1, 6);
    wait_body(0, 20);
    for (int i = 0; i < 14; i++) begin out_rdy = i[0]; cycle(); end
    drain(50);

    // Underrun on the granted source (src1 wins, last grant was src0).
    push_pkt(0, 1, 3); push_pkt(1, 2, 4);
    wait_body(1, 20);
    force_e1 = 1;
    for (int i = 0; i < 3; i++) cycle();
    force_e1 = 0;
    run_until_pkts(m_order.size() + 2, 60);
    check("underrun_src1_first", m_order[m_order.size()-2], 1);
    check("underrun_src0_next", m_order[m_order.size()-1], 0);
    drain(50);

    // Long packet: 10 words with an 8-word limit.
    do_reset(1);
    push_pkt(0, 1, 8);
    wr_cycles = 0;
    drain(50);
    check("long_words", wr_cycles, 10);
    check("long_err", err_long, 1);
    check("long_cnt0", pkt_cnt0, 1);
    for (int i = 0; i < 3; i++) cycle();
    check("long_err_sticky", err_long, 1);

    // Reset mid-body abandons the packet; then counter wrap.
    push_pkt(0, 1, 5);
    wait_body(0, 20);
    cycle();
    do_reset(1);
    cycle();
    check("midrst_cnt0", pkt_cnt0, 0);
    check("midrst_err", err_long, 0);
    for (int i = 0; i < 5; i++) push_pkt(0, 1, 1);
    drain(100);
    check("wrap_cnt0", pkt_cnt0, 1);

    // Randomized traffic with backpressure and underruns.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 11) == 0) push_pkt(0, $urandom_range(1, 2), $urandom_range(1, 7));
      if ($urandom_range(0, 11) == 0) push_pkt(1, $urandom_range(1, 2), $urandom_range(1, 7));
      out_rdy  = ($urandom_range(0, 3) != 0);
      force_e0 = ($urandom_range(0, 9) == 0);
      force_e1 = ($urandom_range(0, 9) == 0);
      cycle();
    end
    drain(2000);
    check("rand_exp0_empty", exp0.size(), 0);
    check("rand_exp1_empty", exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
